// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage. Owns the PC, fetches words over a
// req/ack handshake with variable latency, and feeds IF/ID with instr/PC+4 or
// a NOP bubble. Handles hazard stalls and MEM-stage branch redirects.
// Optional: define IF_FETCH_PERF_EN to add saturating fetch/bubble counters.
`timescale 1ns/1ps
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_next_pc,
    output logic        o_valid
`ifdef IF_FETCH_PERF_EN
   ,output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;     // word captured while stalled
    logic [31:0] pend_q, pend_d;   // redirect target waiting for old ack
    logic [31:0] pc_inc, rpc;
    logic        deliver, bubble;
    logic [31:0] dlv_data;

    assign pc_inc      = pc_q + 32'd4;
    assign rpc         = i_redirect_pc & ~32'h3;
    // Request side is decoded from registered state only.
    assign o_imem_req  = (state_q == FETCH) || (state_q == DISCARD);
    assign o_imem_addr = {pc_q[31:2], 2'b00};

    // Next-state, PC and output-action decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        pend_d   = pend_q;
        deliver  = 1'b0;
        bubble   = 1'b0;
        dlv_data = 32'h0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                bubble  = i_redirect;
            end
            FETCH: begin
                if (i_imem_ack) begin
                    if (i_redirect) begin
                        pc_d   = rpc;
                        bubble = 1'b1;
                    end else if (!i_stall) begin
                        deliver  = 1'b1;
                        dlv_data = i_imem_rdata;
                        pc_d     = pc_inc;
                    end else begin
                        buf_d   = i_imem_rdata;
                        state_d = HOLD;
                    end
                end else begin
                    if (i_redirect) begin
                        // old request must still complete before retargeting
                        pend_d  = rpc;
                        state_d = DISCARD;
                        bubble  = 1'b1;
                    end else if (!i_stall) begin
                        bubble = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_redirect) begin
                    pc_d    = rpc;
                    state_d = FETCH;
                    bubble  = 1'b1;
                end else if (!i_stall) begin
                    deliver  = 1'b1;
                    dlv_data = buf_q;
                    pc_d     = pc_inc;
                    state_d  = FETCH;
                end
            end
            default: begin // DISCARD
                if (i_redirect) pend_d = rpc;
                if (i_imem_ack) begin
                    pc_d    = i_redirect ? rpc : pend_q;
                    state_d = FETCH;
                end
                bubble = i_redirect || !i_stall;
            end
        endcase
    end

    // State, PC, buffers and registered IF/ID outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            buf_q     <= 32'h0;
            pend_q    <= 32'h0;
            o_valid   <= 1'b0;
            o_instr   <= 32'h0;
            o_next_pc <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            if (bubble) begin
                o_valid   <= 1'b0;
                o_instr   <= 32'h0;
                o_next_pc <= 32'h0;
            end else if (deliver) begin
                o_valid   <= 1'b1;
                o_instr   <= dlv_data;
                o_next_pc <= pc_inc;
            end
        end
    end

`ifdef IF_FETCH_PERF_EN
    // Saturating counters of delivered instructions and bubble actions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fetch_cnt  <= 32'h0;
            o_bubble_cnt <= 32'h0;
        end else begin
            if (deliver && o_fetch_cnt != 32'hFFFF_FFFF)
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            if (bubble && o_bubble_cnt != 32'hFFFF_FFFF)
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the fetch stage.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_stall = 1'b0, i_redirect = 1'b0, i_imem_ack = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0, i_imem_rdata = 32'h0;
    logic        o_imem_req, o_valid;
    logic [31:0] o_imem_addr, o_instr, o_next_pc;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] o_fetch_cnt, o_bubble_cnt;
`endif

    int checks = 0;
    int failures = 0;

    if_fetch_stage #(.RESET_PC(RPC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .o_instr(o_instr), .o_next_pc(o_next_pc), .o_valid(o_valid)
`ifdef IF_FETCH_PERF_EN
       ,.o_fetch_cnt(o_fetch_cnt), .o_bubble_cnt(o_bubble_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a started flag, an outstanding word held back by a stall, and
    // a pending retarget that waits for the abandoned fetch to complete.
    logic [31:0] m_pc, m_buf, m_pend, m_instr, m_npc, m_fcnt, m_bcnt;
    logic        m_started, m_hbuf, m_disc, m_valid;

    task automatic m_reset();
        m_pc = RPC; m_buf = 0; m_pend = 0; m_instr = 0; m_npc = 0;
        m_started = 0; m_hbuf = 0; m_disc = 0; m_valid = 0;
        m_fcnt = 0; m_bcnt = 0;
    endtask

    task automatic m_bubble();
        m_valid = 0; m_instr = 0; m_npc = 0; m_bcnt++;
    endtask

    task automatic m_deliver(input logic [31:0] w);
        m_valid = 1; m_instr = w; m_npc = m_pc + 4; m_pc = m_pc + 4; m_fcnt++;
    endtask

    // At a negedge: compare outputs, apply inputs, advance model, wait a cycle.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt,
                        input logic ak, input logic [31:0] dat);
        logic [31:0] t;
        chk("valid", {31'h0, o_valid}, {31'h0, m_valid});
        chk("instr", o_instr, m_instr);
        chk("next_pc", o_next_pc, m_npc);
        chk("req", {31'h0, o_imem_req}, {31'h0, m_started && !m_hbuf});
        chk("addr", o_imem_addr, m_pc);
`ifdef IF_FETCH_PERF_EN
        chk("fetch_cnt", o_fetch_cnt, m_fcnt);
        chk("bubble_cnt", o_bubble_cnt, m_bcnt);
`endif
        i_stall = st; i_redirect = rd; i_redirect_pc = tgt;
        i_imem_ack = ak; i_imem_rdata = dat;
        t = {tgt[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1;
            if (rd) m_bubble();
        end else if (m_hbuf) begin
            if (rd) begin m_pc = t; m_hbuf = 0; m_bubble(); end
            else if (!st) begin m_hbuf = 0; m_deliver(m_buf); end
        end else if (m_disc) begin
            if (rd) m_pend = t;
            if (ak) begin m_pc = m_pend; m_disc = 0; end
            if (rd || !st) m_bubble();
        end else if (ak) begin
            if (rd) begin m_pc = t; m_bubble(); end
            else if (!st) m_deliver(dat);
            else begin m_buf = dat; m_hbuf = 1; end
        end else begin
            if (rd) begin m_pend = t; m_disc = 1; m_bubble(); end
            else if (!st) m_bubble();
        end
        @(negedge i_clk);
    endtask

    initial begin
        m_reset();
        @(negedge i_clk);
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_req", {31'h0, o_imem_req}, 32'h0);
        chk("rst_addr", o_imem_addr, RPC);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(0, 0, 0, 0, 0);                 // IDLE cycle, no request yet

        // zero-wait memory, rdata = addr
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", o_imem_addr, RPC + 4 * i);
            step(0, 0, 0, 1, RPC + 4 * i);
            chk("seq_instr", o_instr, RPC + 4 * i);
            chk("seq_npc", o_next_pc, RPC + 4 * i + 4);
            chk("seq_valid", {31'h0, o_valid}, 32'h1);
        end

        // slow memory at 0x100
        step(0, 1, 32'h100, 0, 0);
        step(0, 0, 0, 1, 32'hBAD0_0001);
        for (int i = 0; i < 3; i++) begin
            chk("slow_addr", o_imem_addr, 32'h100);
            step(0, 0, 0, 0, 32'hBAD0_0002);
            chk("slow_bubble", {31'h0, o_valid}, 32'h0);
        end
        step(0, 0, 0, 1, 32'h2008_0005);
        chk("slow_instr", o_instr, 32'h2008_0005);
        chk("slow_npc", o_next_pc, 32'h104);

        // stall on the ack cycle at 0x200
        step(0, 1, 32'h200, 1, 0);
        step(1, 0, 0, 1, 32'hA5A5_1234);
        chk("hold_req", {31'h0, o_imem_req}, 32'h0);
        step(1, 0, 0, 1, 32'hBAD0_0003);
        step(0, 0, 0, 0, 0);
        chk("hold_instr", o_instr, 32'hA5A5_1234);
        chk("hold_npc", o_next_pc, 32'h204);
        chk("hold_next_addr", o_imem_addr, 32'h204);

        // redirect while 0x80 is outstanding
        step(0, 1, 32'h80, 1, 0);
        step(0, 1, 32'h300, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0080);
        chk("disc_valid", {31'h0, o_valid}, 32'h0);
        chk("disc_addr", o_imem_addr, 32'h300);

        // redirect with stall, misaligned target
        step(0, 0, 0, 1, 32'h1111_1111);
        step(1, 1, 32'h402, 1, 32'h2222_2222);
        chk("rdst_valid", {31'h0, o_valid}, 32'h0);
        chk("rdst_addr", o_imem_addr, 32'h400);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 1, 0);
        step(0, 0, 0, 1, 32'h3333_3333);
        chk("wrap_npc", o_next_pc, 32'h0);
        chk("wrap_addr", o_imem_addr, 32'h0);

        // randomized traffic with occasional async reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                i_rst_n = 1'b0;
                #1;
                chk("arst_req", {31'h0, o_imem_req}, 32'h0);
                chk("arst_valid", {31'h0, o_valid}, 32'h0);
                m_reset();
                @(negedge i_clk);
                i_rst_n = 1'b1;
            end
            step($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom,
                 $urandom_range(0, 1) == 1, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
